// File: rtl/main_net_train_sequencer.sv
// Training-run sequencer for one main_net instance.
// Issues BATCH_SIZE samples per epoch for the requested number of epochs, one at a time:
// a one-cycle valid pulse to the net, a wait for its done pulse, then an optional settle gap.
// Adds abort, a per-sample watchdog, and last/max per-sample latency statistics.
module main_net_train_sequencer #(
    parameter int unsigned ADDRESS_WIDTH  = 11,
    parameter int unsigned BATCH_SIZE     = 32,
    parameter int unsigned SAMPLE_STRIDE  = 2,
    parameter int unsigned EPOCH_WIDTH    = 16,
    parameter int unsigned LAT_WIDTH      = 20,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned GAP_CYCLES     = 2,
    localparam int unsigned IDX_WIDTH     = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [EPOCH_WIDTH-1:0]   i_num_epochs,
    input  logic                     i_abort,
    output logic                     o_net_valid,
    input  logic                     i_net_valid,
    output logic [ADDRESS_WIDTH-1:0] o_sample_addr,
    output logic [IDX_WIDTH-1:0]     o_sample_idx,
    output logic [EPOCH_WIDTH-1:0]   o_epoch_idx,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_timeout_err,
    output logic [LAT_WIDTH-1:0]     o_last_latency,
    output logic [LAT_WIDTH-1:0]     o_max_latency
);

    localparam int unsigned GAP_WIDTH = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    // Wide enough that the product never overflows before truncation to the address width.
    localparam int unsigned MUL_WIDTH = ADDRESS_WIDTH + 32;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StIssue = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StGap   = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [EPOCH_WIDTH-1:0]   epochs_q, epochs_d;
    logic [IDX_WIDTH-1:0]     sample_idx_q, sample_idx_d;
    logic [EPOCH_WIDTH-1:0]   epoch_idx_q, epoch_idx_d;
    logic [LAT_WIDTH-1:0]     lat_cnt_q, lat_cnt_d;
    logic [GAP_WIDTH-1:0]     gap_cnt_q, gap_cnt_d;
    logic                     net_valid_q, net_valid_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [LAT_WIDTH-1:0]     last_lat_q, last_lat_d;
    logic [LAT_WIDTH-1:0]     max_lat_q, max_lat_d;
    logic                     last_sample;
    logic                     last_in_batch;

    assign last_in_batch = (sample_idx_q == IDX_WIDTH'(BATCH_SIZE - 1));
    assign last_sample   = last_in_batch && (epoch_idx_q == (epochs_q - EPOCH_WIDTH'(1)));

    // Next-state, counters, statistics and registered-output next values.
    always_comb begin
        state_d      = state_q;
        epochs_d     = epochs_q;
        sample_idx_d = sample_idx_q;
        epoch_idx_d  = epoch_idx_q;
        lat_cnt_d    = lat_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        addr_d       = addr_q;
        err_d        = err_q;
        last_lat_d   = last_lat_q;
        max_lat_d    = max_lat_q;

        case (state_q)
            StIdle: begin
                if (i_start) begin
                    err_d        = 1'b0;
                    max_lat_d    = '0;
                    last_lat_d   = '0;
                    sample_idx_d = '0;
                    epoch_idx_d  = '0;
                    addr_d       = '0;
                    epochs_d     = i_num_epochs;
                    state_d      = (i_num_epochs == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                lat_cnt_d = LAT_WIDTH'(1);
                state_d   = i_abort ? StDone : StWait;
            end
            StWait: begin
                if (i_abort) begin
                    // Abort wins over a simultaneous completion; stats stay untouched.
                    state_d = StDone;
                end else if (i_net_valid) begin
                    last_lat_d = lat_cnt_q;
                    if (lat_cnt_q > max_lat_q) begin
                        max_lat_d = lat_cnt_q;
                    end
                    if (last_sample) begin
                        state_d = StDone;
                    end else begin
                        if (last_in_batch) begin
                            sample_idx_d = '0;
                            epoch_idx_d  = epoch_idx_q + EPOCH_WIDTH'(1);
                        end else begin
                            sample_idx_d = sample_idx_q + IDX_WIDTH'(1);
                        end
                        if (GAP_CYCLES > 0) begin
                            gap_cnt_d = GAP_WIDTH'(1);
                            state_d   = StGap;
                        end else begin
                            state_d = StIssue;
                        end
                    end
                end else if (lat_cnt_q == LAT_WIDTH'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (lat_cnt_q != '1) begin
                    lat_cnt_d = lat_cnt_q + LAT_WIDTH'(1);
                end
            end
            StGap: begin
                if (i_abort) begin
                    state_d = StDone;
                end else if (gap_cnt_q == GAP_WIDTH'(GAP_CYCLES)) begin
                    state_d = StIssue;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_WIDTH'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state itself.
        net_valid_d = (state_d == StIssue);
        busy_d      = (state_d == StIssue) || (state_d == StWait) || (state_d == StGap);
        done_d      = (state_d == StDone);
        if (state_d == StIssue) begin
            addr_d = ADDRESS_WIDTH'(MUL_WIDTH'(sample_idx_d) * MUL_WIDTH'(SAMPLE_STRIDE));
        end
    end

    // State and output registers; asynchronous reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            epochs_q     <= '0;
            sample_idx_q <= '0;
            epoch_idx_q  <= '0;
            lat_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            net_valid_q  <= 1'b0;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            last_lat_q   <= '0;
            max_lat_q    <= '0;
        end else begin
            state_q      <= state_d;
            epochs_q     <= epochs_d;
            sample_idx_q <= sample_idx_d;
            epoch_idx_q  <= epoch_idx_d;
            lat_cnt_q    <= lat_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            net_valid_q  <= net_valid_d;
            addr_q       <= addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            last_lat_q   <= last_lat_d;
            max_lat_q    <= max_lat_d;
        end
    end

    assign o_net_valid    = net_valid_q;
    assign o_sample_addr  = addr_q;
    assign o_sample_idx   = sample_idx_q;
    assign o_epoch_idx    = epoch_idx_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_timeout_err  = err_q;
    assign o_last_latency = last_lat_q;
    assign o_max_latency  = max_lat_q;

endmodule

// File: tb/tb_main_net_train_sequencer.sv
// Bench for main_net_train_sequencer: a stub net answers each o_net_valid after a programmed
// latency; expected sample addresses are queued at start and popped on every net pulse.
module tb_main_net_train_sequencer;

    localparam int AW = 11;
    localparam int BS = 4;
    localparam int STRIDE = 2;
    localparam int EW = 16;
    localparam int LW = 20;
    localparam int TO = 16;
    localparam int GAP = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0;
    logic [EW-1:0] i_num_epochs = '0;
    logic          i_abort = 1'b0;
    logic          i_net_valid = 1'b0;
    logic          o_net_valid;
    logic [AW-1:0] o_sample_addr;
    logic [1:0]    o_sample_idx;
    logic [EW-1:0] o_epoch_idx;
    logic          o_busy;
    logic          o_done;
    logic          o_timeout_err;
    logic [LW-1:0] o_last_latency;
    logic [LW-1:0] o_max_latency;
    logic [72:0]   outs_all;

    assign outs_all = {o_net_valid, o_busy, o_done, o_timeout_err, o_sample_addr, o_sample_idx,
                       o_epoch_idx, o_last_latency, o_max_latency};

    main_net_train_sequencer #(
        .ADDRESS_WIDTH (AW),
        .BATCH_SIZE    (BS),
        .SAMPLE_STRIDE (STRIDE),
        .EPOCH_WIDTH   (EW),
        .LAT_WIDTH     (LW),
        .TIMEOUT_CYCLES(TO),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_num_epochs  (i_num_epochs),
        .i_abort       (i_abort),
        .o_net_valid   (o_net_valid),
        .i_net_valid   (i_net_valid),
        .o_sample_addr (o_sample_addr),
        .o_sample_idx  (o_sample_idx),
        .o_epoch_idx   (o_epoch_idx),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_timeout_err (o_timeout_err),
        .o_last_latency(o_last_latency),
        .o_max_latency (o_max_latency)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int net_cnt = 0;
    int done_cnt = 0;
    int done_cycle = -1;
    int issue_cycle = -1;
    int start_cycle = -1;
    int abort_cycle = -1;
    bit busy_seen = 1'b0;
    logic [AW-1:0] exp_addr_q[$];
    logic [AW-1:0] exp_a;

    // Stub net controls
    bit stub_en = 1'b1;
    bit stub_use_tab = 1'b0;
    int stub_fixed = 5;
    int lat_tab[4] = '{3, 9, 4, 7};
    int abort_at = -1;
    int stub_cnt = 0;
    int stub_pulse = 0;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Stub net: i_net_valid high in the cycle N after the o_net_valid cycle.
    initial forever begin
        @(negedge clk);
        i_net_valid = 1'b0;
        i_abort = 1'b0;
        if (rst) begin
            stub_cnt = 0;
        end else begin
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    i_net_valid = 1'b1;
                    if (stub_pulse - 1 == abort_at) begin
                        i_abort = 1'b1;
                        abort_cycle = cyc;
                    end
                end
            end
            if (o_net_valid && stub_en) begin
                stub_cnt = stub_use_tab ? lat_tab[stub_pulse % 4] : stub_fixed;
                stub_pulse++;
            end
        end
    end

    // Scoreboard monitor: every net pulse pops one expected address.
    initial forever begin
        @(negedge clk);
        if (o_net_valid) begin
            net_cnt++;
            issue_cycle = cyc;
            checks++;
            if (exp_addr_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_net_pulse addr=%0d required=no pulse", o_sample_addr);
            end else begin
                exp_a = exp_addr_q.pop_front();
                if (o_sample_addr !== exp_a) begin
                    failures++;
                    $display("FAIL sample_addr got=%0d exp=%0d", o_sample_addr, exp_a);
                end
            end
        end
        if (o_done) begin
            done_cnt++;
            done_cycle = cyc;
        end
        if (o_busy) busy_seen = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_addrs(input int n);
        for (int i = 0; i < n; i++) exp_addr_q.push_back(AW'((i % BS) * STRIDE));
    endtask

    task automatic do_start(input int e);
        step();
        i_start = 1'b1;
        i_num_epochs = EW'(e);
        stub_pulse = 0;
        start_cycle = cyc;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        if (done_cnt == d0) begin
            checks++;
            failures++;
            $display("FAIL %s_done_wait got=no o_done exp=o_done within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        step();
        step();
        checks++;
        if (outs_all !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", outs_all);
        end
        rst = 1'b0;
        step();
        checks++;
        if (outs_all !== '0) begin
            failures++;
            $display("FAIL idle_after_reset got=%h exp=0", outs_all);
        end
    endtask

    task automatic test_train();
        int n0 = net_cnt;
        int d0 = done_cnt;
        stub_en = 1'b1; stub_use_tab = 1'b0; stub_fixed = 5; abort_at = -1;
        push_addrs(8);
        do_start(2);
        wait_done(d0, 400, "train");
        checks += 7;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL train_busy got=%0b exp=0", o_busy); end
        if (net_cnt - n0 != 8) begin
            failures++; $display("FAIL train_pulses got=%0d exp=8", net_cnt - n0);
        end
        if (o_last_latency !== LW'(5)) begin
            failures++; $display("FAIL train_last_lat got=%0d exp=5", o_last_latency);
        end
        if (o_max_latency !== LW'(5)) begin
            failures++; $display("FAIL train_max_lat got=%0d exp=5", o_max_latency);
        end
        if (o_timeout_err !== 1'b0) begin
            failures++; $display("FAIL train_err got=%0b exp=0", o_timeout_err);
        end
        if (o_sample_idx !== 2'd3 || o_epoch_idx !== EW'(1)) begin
            failures++;
            $display("FAIL train_final_idx got=%0d/%0d exp=3/1", o_sample_idx, o_epoch_idx);
        end
        if (exp_addr_q.size() != 0) begin
            failures++; $display("FAIL train_missing_pulses got=%0d left exp=0", exp_addr_q.size());
        end
        repeat (10) step();
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++; $display("FAIL train_done_count got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_zero_epochs();
        int n0 = net_cnt;
        int d0 = done_cnt;
        busy_seen = 1'b0;
        do_start(0);
        wait_done(d0, 10, "zero");
        checks++;
        if (done_cycle - start_cycle < 1 || done_cycle - start_cycle > 2) begin
            failures++;
            $display("FAIL zero_done_delay got=%0d exp=1..2", done_cycle - start_cycle);
        end
        repeat (5) step();
        checks += 3;
        if (net_cnt != n0) begin failures++; $display("FAIL zero_pulses got=%0d exp=0", net_cnt - n0); end
        if (busy_seen) begin failures++; $display("FAIL zero_busy got=1 exp=0"); end
        if (done_cnt - d0 != 1) begin
            failures++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        int n0 = net_cnt;
        int d0 = done_cnt;
        stub_en = 1'b0;
        push_addrs(1);
        do_start(1);
        wait_done(d0, 100, "timeout");
        checks += 4;
        if (o_timeout_err !== 1'b1) begin
            failures++; $display("FAIL timeout_err got=%0b exp=1", o_timeout_err);
        end
        if (done_cycle - (issue_cycle + 1) != TO) begin
            failures++;
            $display("FAIL timeout_delay got=%0d exp=%0d", done_cycle - (issue_cycle + 1), TO);
        end
        if (net_cnt - n0 != 1) begin
            failures++; $display("FAIL timeout_pulses got=%0d exp=1", net_cnt - n0);
        end
        if (o_last_latency !== '0) begin
            failures++; $display("FAIL timeout_last_lat got=%0d exp=0", o_last_latency);
        end
        // A fresh start clears the sticky error straight away.
        stub_en = 1'b1;
        stub_fixed = 5;
        d0 = done_cnt;
        push_addrs(4);
        do_start(1);
        checks++;
        if (o_timeout_err !== 1'b0) begin
            failures++; $display("FAIL timeout_clear got=%0b exp=0", o_timeout_err);
        end
        wait_done(d0, 200, "timeout_rerun");
        checks++;
        if (o_timeout_err !== 1'b0 || o_last_latency !== LW'(5)) begin
            failures++;
            $display("FAIL rerun_stats got=err%0b/lat%0d exp=err0/lat5", o_timeout_err, o_last_latency);
        end
    endtask

    task automatic test_latency_table();
        int d0 = done_cnt;
        stub_use_tab = 1'b1;
        push_addrs(4);
        do_start(1);
        wait_done(d0, 200, "lat_tab");
        checks += 2;
        if (o_last_latency !== LW'(7)) begin
            failures++; $display("FAIL tab_last_lat got=%0d exp=7", o_last_latency);
        end
        if (o_max_latency !== LW'(9)) begin
            failures++; $display("FAIL tab_max_lat got=%0d exp=9", o_max_latency);
        end
        stub_use_tab = 1'b0;
    endtask

    task automatic test_abort();
        int n0 = net_cnt;
        int d0 = done_cnt;
        stub_fixed = 4;
        abort_at = 2;
        abort_cycle = -1;
        push_addrs(3);
        do_start(2);
        repeat (3) step();
        // Start while busy must be ignored.
        i_start = 1'b1;
        i_num_epochs = EW'(7);
        step();
        i_start = 1'b0;
        wait_done(d0, 200, "abort");
        checks += 4;
        if (done_cycle != abort_cycle + 1) begin
            failures++;
            $display("FAIL abort_done_cycle got=%0d exp=%0d", done_cycle, abort_cycle + 1);
        end
        if (o_last_latency !== LW'(4) || o_max_latency !== LW'(4)) begin
            failures++;
            $display("FAIL abort_stats got=%0d/%0d exp=4/4", o_last_latency, o_max_latency);
        end
        if (o_sample_idx !== 2'd2 || o_epoch_idx !== EW'(0)) begin
            failures++;
            $display("FAIL abort_idx got=%0d/%0d exp=2/0", o_sample_idx, o_epoch_idx);
        end
        if (o_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", o_busy); end
        repeat (15) step();
        checks += 2;
        if (net_cnt - n0 != 3) begin
            failures++; $display("FAIL abort_pulses got=%0d exp=3", net_cnt - n0);
        end
        if (done_cnt - d0 != 1) begin
            failures++; $display("FAIL abort_done_count got=%0d exp=1", done_cnt - d0);
        end
        abort_at = -1;
    endtask

    task automatic test_reset_mid_run();
        int n0 = net_cnt;
        int d0 = done_cnt;
        int n = 0;
        stub_fixed = 5;
        push_addrs(4);
        do_start(1);
        while (net_cnt - n0 < 2 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (net_cnt - n0 < 2) begin
            failures++; $display("FAIL rst_reach_wait got=%0d pulses exp=2", net_cnt - n0);
        end
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (outs_all !== '0) begin
            failures++; $display("FAIL rst_async_outputs got=%h exp=0", outs_all);
        end
        step();
        step();
        checks++;
        if (done_cnt != d0) begin
            failures++; $display("FAIL rst_no_done got=%0d exp=0", done_cnt - d0);
        end
        exp_addr_q.delete();
        rst = 1'b0;
        step();
        n0 = net_cnt;
        d0 = done_cnt;
        push_addrs(4);
        do_start(1);
        wait_done(d0, 200, "rst_rerun");
        checks += 2;
        if (net_cnt - n0 != 4 || exp_addr_q.size() != 0) begin
            failures++; $display("FAIL rst_rerun_pulses got=%0d exp=4", net_cnt - n0);
        end
        if (o_last_latency !== LW'(5) || o_timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_rerun_stats got=lat%0d/err%0b exp=lat5/err0", o_last_latency,
                     o_timeout_err);
        end
    endtask

    initial begin
        test_reset();
        test_train();
        test_zero_epochs();
        test_timeout();
        test_latency_table();
        test_abort();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
